// File: rtl/vec_pkg.sv
// Shared vector datapath definitions for the load unit, vector ALU and register file.
// Lane k of a vector occupies bits [LANE_W*k +: LANE_W].
package vec_pkg;

  localparam int LANES  = 16;
  localparam int LANE_W = 16;
  localparam int VEC_W  = LANES * LANE_W;
  localparam int ADDR_W = 16;
  localparam int REG_W  = 4;
  localparam int IDX_W  = $clog2(LANES);

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [VEC_W-1:0]  vec_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WB} ld_state_t;

  // A broadcast load issues a single read; a vector load issues one read per lane.
  function automatic idx_t last_issue_idx(input logic bcast);
    return bcast ? idx_t'(0) : idx_t'(LANES - 1);
  endfunction

endpackage

// File: rtl/vec_lane_assembler.sv
// Lane-addressed vector register: writes one lane per strobe, or every lane at once
// when wr_all is set. Reset clears all lanes.
module vec_lane_assembler
  import vec_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  logic  wr_all,
  input  idx_t  wr_idx,
  input  lane_t wr_data,
  output vec_t  vec
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_all || (wr_idx == idx_t'(k))) begin
          vec[k*LANE_W +: LANE_W] <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/vec_load_unit.sv
// Operand-fetch stage: gathers a 256-bit vector (or one broadcast scalar) from a
// 16-bit synchronous RAM and presents it to the register file with a one-cycle wb_en.
module vec_load_unit
  import vec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              broadcast,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [REG_W-1:0]  dest_reg,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [LANE_W-1:0] mem_rdata,
  output logic              busy,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_reg,
  output logic [VEC_W-1:0]  vec_out
);

  ld_state_t         state, state_next;
  logic [ADDR_W-1:0] base_q;
  logic              bcast_q;
  idx_t              issue_idx;
  logic              issue_last;
  logic              cap_en;
  idx_t              cap_idx;

  assign issue_last = (issue_idx == last_issue_idx(bcast_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    busy       = 1'b1;
    wb_en      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = ISSUE;
      end
      ISSUE: begin
        mem_rd_en = 1'b1;
        mem_addr  = base_q + ADDR_W'(issue_idx);
        if (issue_last) state_next = DRAIN;
      end
      DRAIN: state_next = WB;
      WB: begin
        wb_en      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request parameters are only taken in IDLE, so start while busy is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      bcast_q   <= 1'b0;
      wb_reg    <= '0;
      issue_idx <= '0;
    end else begin
      if (state == IDLE && start) begin
        base_q    <= base_addr;
        bcast_q   <= broadcast;
        wb_reg    <= dest_reg;
        issue_idx <= '0;
      end else if (state == ISSUE) begin
        issue_idx <= issue_last ? '0 : issue_idx + idx_t'(1);
      end
    end
  end

  // Read data returns one cycle after the strobe, so capture follows issue by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_en  <= 1'b0;
      cap_idx <= '0;
    end else begin
      cap_en  <= mem_rd_en;
      cap_idx <= issue_idx;
    end
  end

  vec_lane_assembler u_assembler (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cap_en),
    .wr_all  (bcast_q),
    .wr_idx  (cap_idx),
    .wr_data (mem_rdata),
    .vec     (vec_out)
  );

endmodule

// File: tb/tb_vec_load_unit.sv
// Self-checking bench for vec_load_unit: table-driven directed loads, randomized loads
// against a memory-array reference model, and hand-written start-while-busy / reset-abort sequences.
module tb_vec_load_unit;
  import vec_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              broadcast = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [REG_W-1:0]  dest_reg = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [LANE_W-1:0] mem_rdata = '0;
  logic              busy;
  logic              wb_en;
  logic [REG_W-1:0]  wb_reg;
  logic [VEC_W-1:0]  vec_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:65535];

  logic [15:0]  obs_last_addr;
  int           obs_wb_cycle;
  int           obs_wb_count;
  logic [255:0] obs_vec;

  typedef struct {
    logic [15:0] base;
    logic [3:0]  dest;
    logic        bc;
    logic [15:0] exp_last_addr;
    int          exp_wb_cycle;
    logic [15:0] exp_lane8;
    logic [15:0] exp_lane15;
  } load_case_t;

  load_case_t cases [5];

  vec_load_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .broadcast (broadcast),
    .base_addr (base_addr),
    .dest_reg  (dest_reg),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .vec_out   (vec_out)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference vector: lane k holds mem[base+k mod 2^16], or mem[base] in every lane for broadcast.
  function automatic logic [255:0] model_vector(input logic [15:0] base, input logic bc);
    logic [255:0] v;
    logic [15:0]  a;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      a = bc ? base : base + 16'(k);
      v[k*16 +: 16] = mem[a];
    end
    return v;
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Called at a negedge: that cycle is cycle 0. Checks every cycle through cycle n+3.
  task automatic apply_stimulus(input logic [15:0] base, input logic [3:0] dest, input logic bc,
                                input int spur_a, input int spur_b);
    int           n;
    logic [255:0] exp_vec;
    logic [15:0]  exp_addr;
    n       = bc ? 1 : 16;
    exp_vec = model_vector(base, bc);
    obs_wb_count  = 0;
    obs_wb_cycle  = -1;
    obs_last_addr = '0;
    obs_vec       = '0;
    start     = 1'b1;
    broadcast = bc;
    base_addr = base;
    dest_reg  = dest;
    for (int c = 1; c <= n + 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      start     = 1'b0;
      base_addr = 16'($urandom);
      dest_reg  = 4'($urandom);
      broadcast = 1'($urandom);
      check_output($sformatf("rd_en c%0d", c), mem_rd_en, (c <= n));
      if (c <= n) begin
        exp_addr = base + 16'(c - 1);
        check_output($sformatf("mem_addr c%0d", c), mem_addr, exp_addr);
      end
      check_output($sformatf("busy c%0d", c), busy, (c <= n + 2));
      check_output($sformatf("wb_en c%0d", c), wb_en, (c == n + 2));
      if (mem_rd_en) obs_last_addr = mem_addr;
      if (wb_en) begin
        obs_wb_count++;
        obs_wb_cycle = c;
        obs_vec      = vec_out;
        check_output("wb_reg", wb_reg, dest);
        check_output("vec_out at wb", vec_out, exp_vec);
      end
      if (c == spur_a || c == spur_b) start = 1'b1;
    end
    start = 1'b0;
    check_output("wb_en count", obs_wb_count, 1);
  endtask

  initial begin
    logic [15:0] rb;
    logic [3:0]  rd;
    logic        rbc;
    int          wb_seen;

    for (int a = 0; a < 65536; a++) mem[a] = ~16'(a);
    mem[16'h0100] = 16'h0140; mem[16'h0101] = 16'h0000; mem[16'h0102] = 16'h0000;
    mem[16'h0103] = 16'h0000; mem[16'h0104] = 16'h0000; mem[16'h0105] = 16'h0000;
    mem[16'h0106] = 16'h0000; mem[16'h0107] = 16'h0000; mem[16'h0108] = 16'h0140;
    mem[16'h0109] = 16'h0300; mem[16'h010A] = 16'h0080; mem[16'h010B] = 16'h0180;
    mem[16'h010C] = 16'h0380; mem[16'h010D] = 16'h0140; mem[16'h010E] = 16'h0180;
    mem[16'h010F] = 16'h0000;
    mem[16'h0200] = 16'hFF00;

    cases[0] = '{16'h0100, 4'd3,  1'b0, 16'h010F, 18, 16'h0140, 16'h0000};
    cases[1] = '{16'h0200, 4'd7,  1'b1, 16'h0200,  3, 16'hFF00, 16'hFF00};
    cases[2] = '{16'hFFF8, 4'd5,  1'b0, 16'h0007, 18, 16'hFFFF, 16'hFFF8};
    cases[3] = '{16'hFFFF, 4'd15, 1'b0, 16'h000E, 18, 16'hFFF8, 16'hFFF1};
    cases[4] = '{16'h1234, 4'd0,  1'b1, 16'h1234,  3, 16'hEDCB, 16'hEDCB};

    // Reset and idle.
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_output("reset mem_rd_en", mem_rd_en, 0);
    check_output("reset mem_addr", mem_addr, 0);
    check_output("reset busy", busy, 0);
    check_output("reset wb_en", wb_en, 0);
    check_output("reset wb_reg", wb_reg, 0);
    check_output("reset vec_out", vec_out, 0);
    idle_cycles(2);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      idle_cycles(1);
      check_output($sformatf("idle rd_en %0d", c), mem_rd_en, 0);
      check_output($sformatf("idle busy %0d", c), busy, 0);
    end

    // Directed table, issued back to back.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(cases[i].base, cases[i].dest, cases[i].bc, 0, 0);
      check_output($sformatf("case%0d wb cycle", i), obs_wb_cycle, cases[i].exp_wb_cycle);
      check_output($sformatf("case%0d last addr", i), obs_last_addr, cases[i].exp_last_addr);
      check_output($sformatf("case%0d lane8", i), obs_vec[8*16 +: 16], cases[i].exp_lane8);
      check_output($sformatf("case%0d lane15", i), obs_vec[15*16 +: 16], cases[i].exp_lane15);
    end

    // start pulses while busy are dropped; a start in cycle 19 is accepted immediately.
    idle_cycles(3);
    apply_stimulus(16'h0100, 4'd3, 1'b0, 5, 10);
    apply_stimulus(16'h0200, 4'd7, 1'b1, 0, 0);

    // Randomized loads.
    for (int i = 0; i < 8; i++) begin
      rb  = 16'($urandom);
      rd  = 4'($urandom);
      rbc = 1'($urandom_range(0, 1));
      for (int k = 0; k < 16; k++) mem[rb + 16'(k)] = 16'($urandom);
      idle_cycles($urandom_range(0, 2));
      apply_stimulus(rb, rd, rbc, 0, 0);
    end

    // Reset in cycle 9 of a vector load aborts it and clears the partial vector.
    idle_cycles(1);
    start = 1'b1; broadcast = 1'b0; base_addr = 16'h0300; dest_reg = 4'd9;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_output("abort mem_rd_en", mem_rd_en, 0);
    check_output("abort mem_addr", mem_addr, 0);
    check_output("abort busy", busy, 0);
    check_output("abort wb_en", wb_en, 0);
    check_output("abort wb_reg", wb_reg, 0);
    check_output("abort vec_out", vec_out, 0);
    @(negedge clk);
    idle_cycles(1);
    rst_n = 1'b1;
    wb_seen = 0;
    for (int c = 0; c < 20; c++) begin
      idle_cycles(1);
      if (wb_en) wb_seen++;
    end
    check_output("abort wb_en count", wb_seen, 0);
    apply_stimulus(16'h0100, 4'd3, 1'b0, 0, 0);
    check_output("post-abort lane0", obs_vec[15:0], 16'h0140);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
